// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: widths, ALU function codes and instruction opcodes.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned NUM_REGS       = 8;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int unsigned ALU_OP_WIDTH   = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_FWD = 3'b000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 3'b001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 3'b011;

  // Instruction opcodes decoded by the controller
  localparam logic [7:0] LOADI = 8'h00;
  localparam logic [7:0] MOV   = 8'h01;
  localparam logic [7:0] ADD   = 8'h02;
  localparam logic [7:0] SUB   = 8'h03;
  localparam logic [7:0] AND   = 8'h04;
  localparam logic [7:0] OR    = 8'h05;
  localparam logic [7:0] J     = 8'h06;
  localparam logic [7:0] BEQ   = 8'h07;

endpackage

// File: rtl/alu8.sv
// Combinational ALU: forward, add (carry dropped), and, or; reserved codes yield zero.
module alu8
  import cpu_pkg::*;
(
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]   data1,
  input  logic [DATA_WIDTH-1:0]   data2,
  output logic [DATA_WIDTH-1:0]   result_c
);

  always_comb begin
    result_c = '0;
    case (alu_op)
      ALU_FWD: result_c = data2;
      ALU_ADD: result_c = DATA_WIDTH'(data1 + data2);
      ALU_AND: result_c = data1 & data2;
      ALU_OR:  result_c = data1 | data2;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/rf8x8.sv
// Register file: two asynchronous read ports, one synchronous write port, synchronous clear.
module rf8x8
  import cpu_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      write,
  input  logic [REG_ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [REG_ADDR_WIDTH-1:0] out1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] out2_addr,
  output logic [DATA_WIDTH-1:0]     out1,
  output logic [DATA_WIDTH-1:0]     out2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Clear wins over write; no read bypass, so reads see the old value until the edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs <= '{default: '0};
    end else if (write) begin
      regs[in_addr] <= in_data;
    end
  end

  assign out1 = regs[out1_addr];
  assign out2 = regs[out2_addr];

endmodule

// File: rtl/regfile_alu_core.sv
// Register file plus ALU; the ALU result is the write-back data. Wiring only.
module regfile_alu_core
  import cpu_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WRITE,
  input  logic [REG_ADDR_WIDTH-1:0] IN_ADDR,
  input  logic [REG_ADDR_WIDTH-1:0] OUT1_ADDR,
  input  logic [REG_ADDR_WIDTH-1:0] OUT2_ADDR,
  input  logic [ALU_OP_WIDTH-1:0]   ALU_OP,
  input  logic [DATA_WIDTH-1:0]     OPERAND2,
  output logic [DATA_WIDTH-1:0]     OUT1,
  output logic [DATA_WIDTH-1:0]     OUT2,
  output logic [DATA_WIDTH-1:0]     ALU_RESULT
);

  rf8x8 u_rf (
    .CLK       (CLK),
    .RESET     (RESET),
    .write     (WRITE),
    .in_addr   (IN_ADDR),
    .in_data   (ALU_RESULT),
    .out1_addr (OUT1_ADDR),
    .out2_addr (OUT2_ADDR),
    .out1      (OUT1),
    .out2      (OUT2)
  );

  alu8 u_alu (
    .alu_op   (ALU_OP),
    .data1    (OUT1),
    .data2    (OPERAND2),
    .result_c (ALU_RESULT)
  );

endmodule

// File: tb/tb_regfile_alu_core.sv
// Directed self-checking bench for regfile_alu_core.
module tb_regfile_alu_core;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       WRITE;
  logic [2:0] IN_ADDR;
  logic [2:0] OUT1_ADDR;
  logic [2:0] OUT2_ADDR;
  logic [2:0] ALU_OP;
  logic [7:0] OPERAND2;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic [7:0] ALU_RESULT;

  int n_cmp = 0;
  int n_err = 0;

  regfile_alu_core dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .WRITE      (WRITE),
    .IN_ADDR    (IN_ADDR),
    .OUT1_ADDR  (OUT1_ADDR),
    .OUT2_ADDR  (OUT2_ADDR),
    .ALU_OP     (ALU_OP),
    .OPERAND2   (OPERAND2),
    .OUT1       (OUT1),
    .OUT2       (OUT2),
    .ALU_RESULT (ALU_RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] val);
    ALU_OP   = ALU_FWD;
    OPERAND2 = val;
    IN_ADDR  = addr;
    WRITE    = 1'b1;
    tick();
    WRITE    = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; WRITE = 1'b0; IN_ADDR = '0; OUT1_ADDR = '0; OUT2_ADDR = '0;
    ALU_OP = ALU_FWD; OPERAND2 = '0;
    tick();
    RESET = 1'b0;
    #1;
    check("rst_out1", OUT1, 8'h00);
    check("rst_out2", OUT2, 8'h00);

    // fill all registers, r0 included, then read back on both ports
    for (int i = 0; i < 8; i++) load(3'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) begin
      OUT1_ADDR = 3'(i);
      OUT2_ADDR = 3'(7 - i);
      #1;
      check($sformatf("fill_out1_r%0d", i), OUT1, 8'(8'h11 * (i + 1)));
      check($sformatf("fill_out2_r%0d", 7 - i), OUT2, 8'(8'h11 * (8 - i)));
    end

    // reset with a pending write: write must be ignored
    RESET = 1'b1; WRITE = 1'b1; IN_ADDR = 3'd1; ALU_OP = ALU_FWD; OPERAND2 = 8'h5A;
    tick();
    RESET = 1'b0; WRITE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      OUT1_ADDR = 3'(i);
      OUT2_ADDR = 3'(i);
      #1;
      check($sformatf("clr_out1_r%0d", i), OUT1, 8'h00);
      check($sformatf("clr_out2_r%0d", i), OUT2, 8'h00);
    end
    OPERAND2 = 8'h3C;
    #1;
    check("post_rst_fwd", ALU_RESULT, 8'h3C);

    // loadi
    load(3'd4, 8'h05);
    OUT1_ADDR = 3'd4; #1;
    check("loadi_r4", OUT1, 8'h05);
    load(3'd2, 8'h09);
    OUT2_ADDR = 3'd2; #1;
    check("loadi_r2", OUT2, 8'h09);

    // add with wrap, then write back
    load(3'd4, 8'hF0);
    OUT1_ADDR = 3'd4; ALU_OP = ALU_ADD; OPERAND2 = 8'h20; #1;
    check("add_wrap", ALU_RESULT, 8'h10);
    IN_ADDR = 3'd6; WRITE = 1'b1;
    tick();
    WRITE = 1'b0; OUT2_ADDR = 3'd6; #1;
    check("add_wb_r6", OUT2, 8'h10);

    // subtract via complemented operand
    load(3'd4, 8'h05);
    ALU_OP = ALU_ADD; OPERAND2 = 8'hF7; #1;
    check("sub_5_9", ALU_RESULT, 8'hFC);
    load(3'd4, 8'h09);
    ALU_OP = ALU_ADD; OPERAND2 = 8'hFB; #1;
    check("sub_9_5", ALU_RESULT, 8'h04);

    // logic and reserved codes
    load(3'd4, 8'hCC);
    OPERAND2 = 8'hAA;
    ALU_OP = ALU_AND; #1; check("and", ALU_RESULT, 8'h88);
    ALU_OP = ALU_OR;  #1; check("or", ALU_RESULT, 8'hEE);
    ALU_OP = 3'b101;  #1; check("rsvd_101", ALU_RESULT, 8'h00);
    ALU_OP = 3'b111;  #1; check("rsvd_111", ALU_RESULT, 8'h00);

    // write disabled
    load(3'd3, 8'h01);
    ALU_OP = ALU_FWD; OPERAND2 = 8'h77; IN_ADDR = 3'd3; WRITE = 1'b0; #1;
    check("nowr_alu", ALU_RESULT, 8'h77);
    tick();
    OUT1_ADDR = 3'd3; #1;
    check("nowr_r3", OUT1, 8'h01);

    // read-during-write on the same register, r3 = r3 + 1 twice
    ALU_OP = ALU_ADD; OPERAND2 = 8'h01; IN_ADDR = 3'd3; OUT1_ADDR = 3'd3; WRITE = 1'b1; #1;
    check("rdw_pre_out1", OUT1, 8'h01);
    check("rdw_pre_alu", ALU_RESULT, 8'h02);
    tick();
    check("rdw_edge1", OUT1, 8'h02);
    tick();
    WRITE = 1'b0;
    check("rdw_edge2", OUT1, 8'h03);
    OUT2_ADDR = 3'd3; #1;
    check("same_addr_out2", OUT2, 8'h03);
    check("same_addr_out1", OUT1, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
